// File: rtl/mult_adder_tree_pkg.sv
// Shared widths, defaults and sideband type for the conv PE multiply-adder tree.
// Build option MULT_ADDER_SAT_EN is consumed by mult_adder_tree.
package mult_adder_tree_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LANES      = 9;
  localparam int unsigned DEF_ACC_WIDTH  = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned pow = 1; pow < value; pow = pow * 2) bits++;
    return bits;
  endfunction

  // Number of elements left after `level` pairwise reduction levels.
  function automatic int unsigned level_count(input int unsigned lanes, input int unsigned level);
    int unsigned n;
    n = lanes;
    for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  localparam int unsigned PRODUCT_WIDTH = 2 * DEF_DATA_WIDTH;
  localparam int unsigned TREE_WIDTH    = PRODUCT_WIDTH + clog2(DEF_LANES);

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sideband_t;

endpackage

// File: rtl/mult_adder_tree_level.sv
// One registered reduction level of the adder tree: sums adjacent signed pairs,
// passes an odd trailing element through, and carries the beat sideband.
module adder_tree_level
  import mult_adder_tree_pkg::*;
#(
  parameter  int unsigned N_IN  = 2,
  parameter  int unsigned W_IN  = 16,
  localparam int unsigned N_OUT = (N_IN + 1) / 2,
  localparam int unsigned W_OUT = W_IN + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  sideband_t              i_sb,
  input  logic [N_IN*W_IN-1:0]   i_data,
  output sideband_t              o_sb,
  output logic [N_OUT*W_OUT-1:0] o_data
);

  logic [N_OUT*W_OUT-1:0] w_sum;
  logic [N_OUT*W_OUT-1:0] r_data;
  sideband_t              r_sb;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [W_IN-1:0] w_a;
    assign w_a = i_data[2*j*W_IN +: W_IN];
    if (2*j + 1 < N_IN) begin : g_add
      logic [W_IN-1:0] w_b;
      assign w_b = i_data[(2*j+1)*W_IN +: W_IN];
      assign w_sum[j*W_OUT +: W_OUT] = {w_a[W_IN-1], w_a} + {w_b[W_IN-1], w_b};
    end else begin : g_pass
      assign w_sum[j*W_OUT +: W_OUT] = {w_a[W_IN-1], w_a};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sb   <= '0;
      r_data <= '0;
    end else begin
      r_sb <= flush ? '0 : i_sb;
      if (i_sb.valid) r_data <= w_sum;
    end
  end

  assign o_sb   = r_sb;
  assign o_data = r_data;

endmodule

// File: rtl/mult_adder_tree.sv
// Pipelined signed multiply / adder-tree / accumulator for the conv PE.
// Define MULT_ADDER_SAT_EN for a saturating accumulator with sticky out_sat.
module mult_adder_tree
  import mult_adder_tree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          flush,
  input  logic [LANES*DATA_WIDTH-1:0]   in,
  input  logic [LANES*DATA_WIDTH-1:0]   kernel,
  output logic signed [ACC_WIDTH-1:0]   out,
  output logic                          out_valid,
  output logic                          out_sat
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned D  = clog2(LANES);
  localparam int unsigned TW = PW + D;

  sideband_t            w_in_sb, r_m_sb, w_tree_sb;
  logic [LANES*PW-1:0]  w_prod, r_prod;
  logic [TW-1:0]        w_tree_sum;

  assign w_in_sb = {in_valid, in_first, in_last};

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic signed [PW-1:0] w_a, w_b;
    assign w_a = PW'($signed(in[i*DATA_WIDTH +: DATA_WIDTH]));
    assign w_b = PW'($signed(kernel[i*DATA_WIDTH +: DATA_WIDTH]));
    assign w_prod[i*PW +: PW] = w_a * w_b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m_sb <= '0;
      r_prod <= '0;
    end else begin
      r_m_sb <= flush ? '0 : w_in_sb;
      if (in_valid && !flush) r_prod <= w_prod;
    end
  end

  if (D == 0) begin : g_no_tree
    assign w_tree_sum = r_prod;
    assign w_tree_sb  = r_m_sb;
  end else begin : g_tree
    for (genvar k = 0; k < D; k++) begin : g_lvl
      localparam int unsigned NI = level_count(LANES, k);
      localparam int unsigned NO = level_count(LANES, k + 1);
      localparam int unsigned WI = PW + k;
      logic [NI*WI-1:0]     w_din;
      logic [NO*(WI+1)-1:0] w_dout;
      sideband_t            w_sb_i, w_sb_o;
      if (k == 0) begin : g_src
        assign w_din  = r_prod;
        assign w_sb_i = r_m_sb;
      end else begin : g_chain
        assign w_din  = g_lvl[k-1].w_dout;
        assign w_sb_i = g_lvl[k-1].w_sb_o;
      end
      adder_tree_level #(.N_IN(NI), .W_IN(WI)) u_level (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .i_sb   (w_sb_i),
        .i_data (w_din),
        .o_sb   (w_sb_o),
        .o_data (w_dout)
      );
    end
    assign w_tree_sum = g_lvl[D-1].w_dout;
    assign w_tree_sb  = g_lvl[D-1].w_sb_o;
  end

  logic signed [ACC_WIDTH-1:0] r_acc, r_out, w_acc_next;
  logic                        r_out_valid;

`ifdef MULT_ADDER_SAT_EN
  localparam int unsigned SW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;
  logic signed [SW-1:0]   w_base, w_sum_wide;
  logic [SW-ACC_WIDTH:0]  w_top;
  logic                   w_clamp, w_sat_next, r_sat, r_out_sat;

  // The sum is formed one bit wider than either operand; it overflowed ACC_WIDTH
  // exactly when the bits from ACC_WIDTH-1 upward are not all copies of the sign.
  always_comb begin
    w_base     = w_tree_sb.first ? '0 : SW'(r_acc);
    w_sum_wide = w_base + SW'($signed(w_tree_sum));
    w_top      = w_sum_wide[SW-1:ACC_WIDTH-1];
    w_clamp    = !((&w_top) || !(|w_top));
    w_acc_next = w_clamp ? {w_sum_wide[SW-1], {(ACC_WIDTH-1){~w_sum_wide[SW-1]}}}
                         : w_sum_wide[ACC_WIDTH-1:0];
    w_sat_next = (w_tree_sb.first ? 1'b0 : r_sat) | w_clamp;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sat     <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (flush) begin
      r_sat <= 1'b0;
    end else if (w_tree_sb.valid) begin
      r_sat <= w_sat_next;
      if (w_tree_sb.last) r_out_sat <= w_sat_next;
    end
  end

  assign out_sat = r_out_sat;
`else
  always_comb begin
    w_acc_next = (w_tree_sb.first ? '0 : r_acc) + ACC_WIDTH'($signed(w_tree_sum));
  end

  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_tree_sb.valid & w_tree_sb.last;
      if (w_tree_sb.valid) begin
        r_acc <= w_acc_next;
        if (w_tree_sb.last) r_out <= w_acc_next;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mult_adder_tree.sv
// Randomised and directed bench for mult_adder_tree against a cycle-indexed
// behavioural model of beats, flushes and resets.
module tb_mult_adder_tree;

  localparam int DW   = 8;
  localparam int L    = 9;
  localparam int ACCW = 32;
  localparam int SATW = 18;
  localparam int LAT  = 6;
  localparam int NCYC = 4096;
`ifdef MULT_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, in_valid, in_first, in_last, flush;
  logic [L*DW-1:0] d_in, d_ker;
  logic signed [ACCW-1:0] out;
  logic out_valid, out_sat;
  logic signed [SATW-1:0] s_out;
  logic s_valid, s_sat;

  mult_adder_tree #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(ACCW)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .flush(flush), .in(d_in), .kernel(d_ker),
    .out(out), .out_valid(out_valid), .out_sat(out_sat));

  mult_adder_tree #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(SATW)) u_dut18 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .flush(flush), .in(d_in), .kernel(d_ker),
    .out(s_out), .out_valid(s_valid), .out_sat(s_sat));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint fit(input longint v, input int w, input bit sat, output bit clamped);
    longint one, hi, lo, m;
    one = 1;
    hi = (one <<< (w - 1)) - 1;
    lo = -(one <<< (w - 1));
    clamped = 1'b0;
    if (sat) begin
      if (v > hi) begin clamped = 1'b1; return hi; end
      if (v < lo) begin clamped = 1'b1; return lo; end
      return v;
    end
    m = v & ((one <<< w) - 1);
    if (m[w-1]) m = m - (one <<< w);
    return m;
  endfunction

  // Per-cycle record of what was presented; the model replays it LAT cycles later.
  bit     hv[NCYC], hf[NCYC], hl[NCYC], hfl[NCYC], hrst[NCYC];
  longint hsum[NCYC];
  longint m_acc = 0, m_held = 0;
  bit     m_sat = 0, m_hsat = 0;
  int     t_c, c_c;
  longint s_c;
  bit     ev_c, cl_c, kill_c;
  int     npulse = 0;

  always @(negedge clock) begin
    t_c = cyc;
    if (out_valid === 1'b1) npulse++;
    if (t_c < NCYC) begin
      s_c = 0;
      for (int i = 0; i < L; i++)
        s_c += longint'($signed(d_in[i*DW +: DW])) * longint'($signed(d_ker[i*DW +: DW]));
      hv[t_c] = in_valid; hf[t_c] = in_first; hl[t_c] = in_last;
      hfl[t_c] = flush; hrst[t_c] = reset; hsum[t_c] = s_c;
      if (reset) begin
        m_acc = 0; m_sat = 0; m_held = 0;
        chk("reset_valid", longint'(out_valid), 0);
        chk("reset_out", out, 0);
        chk("reset_sat", longint'(out_sat), 0);
      end else begin
        ev_c = 1'b0;
        if (t_c >= 1 && hfl[t_c-1]) begin
          m_acc = 0; m_sat = 0;
        end else if (t_c >= LAT) begin
          c_c = t_c - LAT;
          kill_c = 1'b0;
          for (int j = c_c; j < t_c; j++) if (hfl[j] || hrst[j]) kill_c = 1'b1;
          if (hv[c_c] && !kill_c) begin
            m_acc = fit((hf[c_c] ? 0 : m_acc) + hsum[c_c], ACCW, SAT, cl_c);
            m_sat = (hf[c_c] ? 1'b0 : m_sat) | cl_c;
            if (hl[c_c]) begin ev_c = 1'b1; m_held = m_acc; m_hsat = m_sat; end
          end
        end
        chk("valid", longint'(out_valid), longint'(ev_c));
        if (ev_c) begin
          chk("out", out, m_held);
          chk("out_sat", longint'(out_sat), longint'(m_hsat));
        end else begin
          chk("out_hold", out, m_held);
        end
      end
    end
  end

  function automatic logic [L*DW-1:0] fill(input int v);
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic beat(input bit f, input bit l, input logic [L*DW-1:0] a, input logic [L*DW-1:0] k);
    in_valid = 1'b1; in_first = f; in_last = l; d_in = a; d_ker = k;
    @(posedge clock); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_pulse(output int n, output longint v, output longint sv, output bit ss, output bit sok);
    bit got;
    got = 1'b0; n = 0; v = 0; sv = 0; ss = 1'b0; sok = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (out_valid) begin
        got = 1'b1; v = out; sv = s_out; ss = s_sat; sok = s_valid;
      end
    end
    if (!got) n = 0;
    @(posedge clock); #1;
  endtask

  int n, np0;
  longint v, sv;
  bit ss, sok;
  logic [L*DW-1:0] kv;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; flush = 1'b0;
    d_in = '0; d_ker = '0;
    idle(3);
    reset = 1'b0;
    idle(2);

    beat(1, 1, fill(2), fill(3));
    wait_pulse(n, v, sv, ss, sok);
    chk("single_latency", n, 6);
    chk("single_out", v, 54);

    for (int i = 0; i < L; i++) kv[i*DW +: DW] = DW'(i + 1);
    np0 = npulse;
    beat(1, 0, fill(1), kv); idle(2);
    beat(0, 0, fill(1), kv); idle(2);
    beat(0, 1, fill(1), kv);
    wait_pulse(n, v, sv, ss, sok);
    chk("three_beat_out", v, 135);
    idle(6);
    chk("three_beat_pulses", npulse - np0, 1);

    beat(1, 1, fill(-128), fill(-128));
    wait_pulse(n, v, sv, ss, sok);
    chk("neg_neg_out", v, 147456);
    beat(1, 1, fill(-128), fill(127));
    wait_pulse(n, v, sv, ss, sok);
    chk("neg_pos_out", v, -146304);

    beat(1, 0, fill(5), fill(5));
    idle(1);
    reset = 1'b1; idle(2); reset = 1'b0;
    np0 = npulse;
    beat(1, 1, fill(1), fill(1));
    wait_pulse(n, v, sv, ss, sok);
    chk("post_reset_latency", n, 6);
    chk("post_reset_out", v, 9);
    idle(6);
    chk("post_reset_pulses", npulse - np0, 1);

    np0 = npulse;
    beat(1, 1, fill(3), fill(3));
    flush = 1'b1; idle(1); flush = 1'b0;
    idle(10);
    chk("flush_pulses", npulse - np0, 0);
    chk("flush_out_kept", out, 9);
    beat(1, 1, fill(2), fill(-3));
    wait_pulse(n, v, sv, ss, sok);
    chk("after_flush_latency", n, 6);
    chk("after_flush_out", v, -54);

    beat(1, 0, fill(-128), fill(-128));
    beat(0, 0, fill(-128), fill(-128));
    beat(0, 0, fill(-128), fill(-128));
    beat(0, 1, fill(-128), fill(-128));
    wait_pulse(n, v, sv, ss, sok);
    chk("four_beat_latency", n, 6);
    chk("four_beat_out", v, 589824);
    chk("acc18_valid", longint'(sok), 1);
    chk("acc18_out", sv, SAT ? 131071 : 65536);
    chk("acc18_sat", longint'(ss), SAT ? 1 : 0);

    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_first = ($urandom_range(0, 4) == 0);
      in_last  = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      for (int j = 0; j < L; j++) begin
        d_in[j*DW +: DW]  = DW'($urandom);
        d_ker[j*DW +: DW] = DW'($urandom);
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; flush = 1'b0;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mult_adder_tree.md
# mult_adder_tree

Parametrised, fully pipelined signed multiply-adder tree for the conv PE. Each beat it multiplies LANES input/kernel pairs, reduces them through a registered binary adder tree, and accumulates successive beats into one result framed by first/last flags. One 3x3 window is one beat at LANES=9; multi-channel windows span several beats. It sits between the PE line buffer and the conv output adder, replacing the fixed three-lane tree.

## Interface
- DATA_WIDTH, 8: signed width of each input and kernel element.
- LANES, 9: multiply lanes per beat, ≥1.
- ACC_WIDTH, 32: accumulator/output width; ≥ 2*DATA_WIDTH + clog2(LANES).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_first  in  1  beat starts a new accumulation; sampled only with in_valid.
- in_last  in  1  beat ends the accumulation; sampled only with in_valid.
- flush  in  1  synchronous kill of all in-flight beats and accumulator.
- in  in  LANES*DATA_WIDTH  packed signed data, lane 0 at LSBs.
- kernel  in  LANES*DATA_WIDTH  packed signed weights, lane 0 at LSBs.
- out  out  ACC_WIDTH  signed accumulated result.
- out_valid  out  1  one-cycle pulse: out holds a completed accumulation.
- out_sat  out  1  result was clamped; valid with out_valid.

## Operation
- Stage M: registered product p[i] = in[i]*kernel[i], signed, 2*DATA_WIDTH bits.
- Stages A1..AD, D = clog2(LANES): each level adds adjacent pairs into a register, sign-extended one bit per level. An odd element at a level passes through registered, unchanged. LANES=1 gives D=0.
- Stage C (accumulator): on a valid beat, acc <= (first ? 0 : acc) + sign_extend(tree_sum). Invalid beats leave acc unchanged.
- Last beat: out <= new acc value, out_valid <= 1 for one cycle. out holds until the next last beat.
- first and last on the same beat: single-beat result equal to the tree sum.
- Valid beat with first=0 and no open accumulation (after reset or flush): adds onto acc = 0.
- first flag while an accumulation is open: discards it; no output.
- Gaps (in_valid low) between beats are allowed at any point; no backpressure, one beat accepted per cycle.
- flush: clears every pipeline valid bit and acc to 0 at the next edge. out keeps its value; out_valid is 0 on that edge. A beat presented with flush is dropped.
- Without saturation, arithmetic wraps modulo 2^ACC_WIDTH and out_sat stays 0.

## Timing
- Reset (asynchronous): all valid/first/last pipeline bits 0, acc 0, out 0, out_valid 0, out_sat 0.
- Latency from a last-beat input edge to out_valid: D+2 cycles (M, D tree levels, C). At LANES=9 this is 6.
- Throughput: one beat per cycle; the accumulator adds back-to-back beats with no bubble.
- Reset mid-accumulation discards all partial state. The first post-reset result includes only beats presented after reset deasserts.

## Configuration
- MULT_ADDER_SAT_EN defined: the accumulator add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Saturation is sticky for the remainder of the accumulation.
  - out_sat is 1 with out_valid if any add in that accumulation clamped.
- MULT_ADDER_SAT_EN undefined: two's-complement wrap, out_sat tied 0, no saturation logic.

## Structure
- Shared package (conv bit_width header): DATA_WIDTH, LANES and ACC_WIDTH defaults, clog2 function, derived PRODUCT_WIDTH = 2*DATA_WIDTH and TREE_WIDTH = PRODUCT_WIDTH + clog2(LANES).
- One sub-module, adder_tree_level: one registered reduction level.
  - Parameterised by input count and width.
  - Carries the valid/first/last sideband.
  - Instanced D times by a generate loop.

## Test plan
- LANES=9, DATA_WIDTH=8, single beat first=last=1, all in=2, kernel=3 -> out=54, out_valid pulse exactly 6 cycles later.
- Three beats first/-/last with in=1, kernel=[1..9], gaps of 2 idle cycles between beats -> out=135, one pulse.
- Signed extremes: all in=-128, kernel=-128, one beat -> out=147456. All in=-128, kernel=127, one beat -> out=-146304.
- Reset asserted between beat 1 and beat 2 of an accumulation; new beat first=last=1 with in=1, kernel=1 -> out=9, no stale output.
- flush the cycle after a last beat enters -> no out_valid; out keeps its previous value. A subsequent single beat produces a correct result.
- MULT_ADDER_SAT_EN, ACC_WIDTH=18, four beats each summing 147456 -> out=131071, out_sat=1. Without the macro -> out wraps to 65536, out_sat=0.
